// File: rtl/hdmi_tmds_encoder_n.sv
// hdmi_tmds_encoder_n: TMDS 8b/10b encoder for CHANNELS lanes with DVI running-disparity DC balance.
// Define HDMI_GUARD_BAND_EN to add a 10-deep look-ahead that inserts HDMI video preamble and guard band.
module hdmi_tmds_encoder_n #(
    parameter int unsigned CHANNELS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   active,
    input  logic                   h_sync,
    input  logic                   v_sync,
    input  logic [3:0]             ctl,
    input  logic [CHANNELS*8-1:0]  data_in,
    output logic [CHANNELS*10-1:0] tmds
);

    localparam logic [9:0] CTRL_00  = 10'b1101010100;
    localparam logic [9:0] CTRL_01  = 10'b0010101011;
    localparam logic [9:0] CTRL_10  = 10'b0101010100;
    localparam logic [9:0] CTRL_11  = 10'b1010101011;
    localparam logic [9:0] GUARD_02 = 10'b1011001100;
    localparam logic [9:0] GUARD_1  = 10'b0100110011;

    typedef enum logic [1:0] {
        SYM_CTRL,
        SYM_DATA,
        SYM_PREAMBLE,
        SYM_GUARD
    } sym_kind_t;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n1;
        logic       use_xnor;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int unsigned i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = CTRL_00;
            2'b01:   t = CTRL_01;
            2'b10:   t = CTRL_10;
            default: t = CTRL_11;
        endcase
        return t;
    endfunction

    // Source tuple feeding stage 1: raw inputs (DVI) or the oldest delay-line entry (HDMI).
    logic                  src_active;
    logic                  src_h;
    logic                  src_v;
    logic [3:0]            src_ctl;
    logic [CHANNELS*8-1:0] src_data;
    sym_kind_t             src_kind;

`ifdef HDMI_GUARD_BAND_EN
    localparam int unsigned DEPTH = 10;

    logic [DEPTH-1:0]      dl_active;
    logic [DEPTH-1:0]      dl_h;
    logic [DEPTH-1:0]      dl_v;
    logic [3:0]            dl_ctl  [DEPTH];
    logic [CHANNELS*8-1:0] dl_data [DEPTH];
    logic                  near_active;
    logic                  far_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_active <= '0;
            dl_h      <= '0;
            dl_v      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dl_ctl[i]  <= '0;
                dl_data[i] <= '0;
            end
        end else begin
            dl_active <= {dl_active[DEPTH-2:0], active};
            dl_h      <= {dl_h[DEPTH-2:0], h_sync};
            dl_v      <= {dl_v[DEPTH-2:0], v_sync};
            dl_ctl[0]  <= ctl;
            dl_data[0] <= data_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                dl_ctl[i]  <= dl_ctl[i-1];
                dl_data[i] <= dl_data[i-1];
            end
        end
    end

    // Entry j sits 9-j cycles ahead of the oldest entry; the live input is 10 ahead.
    always_comb begin
        near_active = dl_active[DEPTH-2] | dl_active[DEPTH-3];
        far_active  = (|dl_active[DEPTH-4:0]) | active;
        src_active  = dl_active[DEPTH-1];
        src_h       = dl_h[DEPTH-1];
        src_v       = dl_v[DEPTH-1];
        src_ctl     = dl_ctl[DEPTH-1];
        src_data    = dl_data[DEPTH-1];
        if (src_active) begin
            src_kind = SYM_DATA;
        end else if (near_active) begin
            src_kind = SYM_GUARD;
        end else if (far_active) begin
            src_kind = SYM_PREAMBLE;
            src_ctl  = 4'b0001;
        end else begin
            src_kind = SYM_CTRL;
        end
    end
`else
    always_comb begin
        src_active = active;
        src_h      = h_sync;
        src_v      = v_sync;
        src_ctl    = ctl;
        src_data   = data_in;
        src_kind   = src_active ? SYM_DATA : SYM_CTRL;
    end
`endif

    sym_kind_t s1_kind;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_kind <= SYM_CTRL;
        end else begin
            s1_kind <= src_kind;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        logic [7:0]        lane_data;
        logic [1:0]        lane_ctrl;
        logic [8:0]        s1_qm;
        logic [1:0]        s1_ctrl;
        logic signed [4:0] cnt;
        logic signed [4:0] cnt_next;
        logic signed [4:0] diff;
        logic [3:0]        n1q;
        logic [3:0]        n0q;
        logic              cnt_pos;
        logic [9:0]        sym_next;
        logic [9:0]        sym_q;

        assign lane_data = src_data[8*g +: 8];

        if (g == 0) begin : g_sync_ctrl
            assign lane_ctrl = {src_v, src_h};
        end else begin : g_ctl_ctrl
            assign lane_ctrl = src_ctl[2*(g-1) +: 2];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_qm   <= '0;
                s1_ctrl <= '0;
            end else begin
                s1_qm   <= transition_min(lane_data);
                s1_ctrl <= lane_ctrl;
            end
        end

        // DVI balance: diff = N1 - N0 of q_m[7:0]; the +/-2 terms account for the bit-8 flag.
        always_comb begin
            n1q      = ones8(s1_qm[7:0]);
            n0q      = 4'd8 - n1q;
            diff     = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
            cnt_pos  = !cnt[4] && (cnt != '0);
            sym_next = ctrl_token(s1_ctrl);
            cnt_next = '0;
            case (s1_kind)
                SYM_DATA: begin
                    if (cnt == '0 || n1q == n0q) begin
                        sym_next = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
                        cnt_next = s1_qm[8] ? (cnt + diff) : (cnt - diff);
                    end else if ((cnt_pos && n1q > n0q) || (cnt[4] && n0q > n1q)) begin
                        sym_next = {1'b1, s1_qm[8], ~s1_qm[7:0]};
                        cnt_next = cnt + (s1_qm[8] ? 5'sd2 : 5'sd0) - diff;
                    end else begin
                        sym_next = {1'b0, s1_qm[8], s1_qm[7:0]};
                        cnt_next = cnt - (s1_qm[8] ? 5'sd0 : 5'sd2) + diff;
                    end
                end
                SYM_GUARD: begin
                    sym_next = (g == 1) ? GUARD_1 : GUARD_02;
                end
                default: begin
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt   <= '0;
                sym_q <= CTRL_00;
            end else begin
                cnt   <= cnt_next;
                sym_q <= sym_next;
            end
        end

        assign tmds[10*g +: 10] = sym_q;
    end

endmodule
